// File: rtl/mux_logic_pkg.sv
// Shared types for the mux-based logic pipe: op encodings, FSM states
// and the per-bit gate decode that feeds each 2:1 mux cell.
package mux_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_NAND    = 3'd2,
        OP_NOR     = 3'd3,
        OP_XOR     = 3'd4,
        OP_XNOR    = 3'd5,
        OP_PASS_A  = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    typedef struct packed {
        logic d0;
        logic d1;
    } mux_in_t;

    // Data inputs for one mux cell; the select bit picks d1 when high.
    function automatic mux_in_t gate_data(input logic [2:0] op, input logic b);
        mux_in_t m;
        m = '0;
        case (op)
            OP_AND:    m = '{d0: 1'b0, d1: b};
            OP_OR:     m = '{d0: b,    d1: 1'b1};
            OP_NAND:   m = '{d0: 1'b1, d1: ~b};
            OP_NOR:    m = '{d0: ~b,   d1: 1'b0};
            OP_XOR:    m = '{d0: b,    d1: ~b};
            OP_XNOR:   m = '{d0: ~b,   d1: b};
            OP_PASS_A: m = '{d0: 1'b0, d1: 1'b1};
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mux2_cell.sv
// Single-bit 2:1 multiplexer cell.
module mux2_cell (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_logic_pipe.sv
// Bitwise logic unit built from 2:1 mux cells, with an accumulate FSM
// and a single valid/ready output register.
module mux_logic_pipe
    import mux_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             err,
    output logic [CNT_W-1:0] out_count
);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] res;
    logic             err_acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             illegal;
    logic             in_acc;
    logic             deliver;
    logic             start;
    logic             step;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign illegal  = (op == OP_ILLEGAL);
    assign in_acc   = (state == ACC);
    assign sel      = in_acc ? acc : a;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_in_t d;
        assign d = gate_data(op, b[i]);
        mux2_cell u_cell (
            .sel (sel[i]),
            .d0  (d.d0),
            .d1  (d.d1),
            .y   (res[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        deliver   = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!acc_mode || last) begin
                        deliver = 1'b1;
                    end else begin
                        start     = 1'b1;
                        state_nxt = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    if (last) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The output register only moves on a delivery or a taken result,
    // so a pending result survives a whole accumulation behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            err       <= 1'b0;
            out_count <= '0;
            acc       <= '0;
            err_acc   <= 1'b0;
            cnt       <= '0;
        end else begin
            if (deliver) begin
                out_valid <= 1'b1;
                y         <= res;
                err       <= illegal | (in_acc & err_acc);
                out_count <= in_acc ? cnt_inc : CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (start) begin
                acc     <= res;
                err_acc <= illegal;
                cnt     <= CNT_W'(1);
            end else if (step) begin
                acc     <= res;
                err_acc <= err_acc | illegal;
                cnt     <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_mux_logic_pipe.sv
// Scoreboard bench for mux_logic_pipe: directed vectors plus random
// beats checked against a boolean reference model.
module tb_mux_logic_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             err;
    logic [CNT_W-1:0] out_count;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             err;
        int               cnt;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    bit               m_seq;
    logic [WIDTH-1:0] m_acc;
    bit               m_err;
    int               m_cnt;

    int               ready_mode;
    bit               checking;
    logic [WIDTH-1:0] got_y;
    logic             got_err;
    int               got_cnt;
    int               n_out;

    mux_logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_mode  (acc_mode),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_op(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] v,
                                                  input logic [2:0] o);
        case (o)
            3'd0:    return s & v;
            3'd1:    return s | v;
            3'd2:    return ~(s & v);
            3'd3:    return ~(s | v);
            3'd4:    return s ^ v;
            3'd5:    return ~(s ^ v);
            3'd6:    return s;
            default: return '0;
        endcase
    endfunction

    task automatic model_accept(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                input logic [2:0] vo, input bit am, input bit lst);
        logic [WIDTH-1:0] r;
        bit il;
        il = (vo == 3'd7);
        if (!m_seq) begin
            r = model_op(va, vb, vo);
            if (!am || lst) begin
                q.push_back('{y: r, err: il, cnt: 1});
            end else begin
                m_seq = 1;
                m_acc = r;
                m_err = il;
                m_cnt = 1;
            end
        end else begin
            r = model_op(m_acc, vb, vo);
            if (!lst) begin
                m_acc = r;
                m_err = m_err | il;
                m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            end else begin
                q.push_back('{y: r, err: m_err | il,
                              cnt: (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1});
                m_seq = 0;
            end
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic [2:0] vo, input bit am, input bit lst);
        int guard;
        guard = 0;
        @(negedge clk);
        a = va;
        b = vb;
        op = vo;
        acc_mode = am;
        last = lst;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", guard);
            in_valid = 1'b0;
            return;
        end
        model_accept(va, vb, vo, am, lst);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        ready_mode = 1;
        while ((q.size() != 0 || out_valid) && g < 200) begin
            @(negedge clk);
            #3;
            g++;
        end
        tests++;
        if (q.size() != 0 || out_valid) begin
            fails++;
            $display("FAIL drain: %0d results still expected, out_valid %0b", q.size(), out_valid);
        end
    endtask

    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    bit               stalled = 0;
    logic [WIDTH-1:0] prev_y;
    logic             prev_err;
    logic [CNT_W-1:0] prev_cnt;
    exp_t             e;

    always begin
        @(negedge clk);
        #2;
        if (checking && rst_n) begin
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_y", y, prev_y);
                check("hold_err", err, prev_err);
                check("hold_count", out_count, prev_cnt);
            end
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: y %0h with nothing expected", y);
                end else begin
                    e = q.pop_front();
                    check("y", y, e.y);
                    check("err", err, e.err);
                    check("out_count", out_count, e.cnt);
                end
                got_y = y;
                got_err = err;
                got_cnt = int'(out_count);
                n_out++;
            end
            stalled = out_valid && !out_ready;
            prev_y = y;
            prev_err = err;
            prev_cnt = out_count;
        end else begin
            stalled = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [WIDTH-1:0] dir_b [3];
    logic [2:0]       dir_op [3];
    logic [WIDTH-1:0] dir_y [3];
    int               n0;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        acc_mode = 1'b0;
        last = 1'b0;
        out_ready = 1'b1;
        ready_mode = 1;
        checking = 0;
        n_out = 0;
        m_seq = 0;
        m_acc = '0;
        m_err = 0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_err", err, 0);
        check("rst_count", out_count, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        checking = 1;

        dir_b  = '{8'hCC, 8'hCC, 8'hCC};
        dir_op = '{3'd4, 3'd0, 3'd3};
        dir_y  = '{8'h3C, 8'hC0, 8'h03};
        for (int i = 0; i < 3; i++) begin
            send(8'hF0, dir_b[i], dir_op[i], 0, 0);
            check("single_latency", out_valid, 1);
            drain();
            check("single_y", got_y, dir_y[i]);
            check("single_err", got_err, 0);
            check("single_count", got_cnt, 1);
        end

        n0 = n_out;
        send(8'hFF, 8'h0F, 3'd0, 1, 0);
        send(8'h00, 8'h3C, 3'd1, 1, 0);
        check("acc_no_early_out", out_valid, 0);
        send(8'h5A, 8'hFF, 3'd4, 0, 1);
        drain();
        check("acc_n_out", n_out - n0, 1);
        check("acc_y", got_y, 8'hC0);
        check("acc_count", got_cnt, 3);
        check("acc_err", got_err, 0);

        send(8'hAA, 8'h55, 3'd7, 0, 0);
        drain();
        check("illegal_y", got_y, 8'h00);
        check("illegal_err", got_err, 1);
        send(8'h12, 8'h34, 3'd0, 1, 0);
        send(8'h00, 8'h56, 3'd7, 1, 0);
        send(8'h00, 8'hFF, 3'd1, 1, 1);
        drain();
        check("illegal_acc_err", got_err, 1);
        check("illegal_acc_y", got_y, 8'hFF);

        n0 = n_out;
        ready_mode = 2;
        send(8'h33, 8'h0F, 3'd1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        ready_mode = 1;
        send(8'h0F, 8'hF0, 3'd5, 0, 0);
        check("bp_b2b_1", out_valid, 1);
        send(8'hC3, 8'h99, 3'd6, 0, 0);
        check("bp_b2b_2", out_valid, 1);
        drain();
        check("bp_n_out", n_out - n0, 3);

        for (int i = 0; i < 6; i++) send(8'h81, 8'h00, 3'd1, 1, i == 5);
        drain();
        check("sat_count", got_cnt, CMAX);
        check("sat_y", got_y, 8'h81);

        send(8'h77, 8'h11, 3'd1, 1, 0);
        send(8'h00, 8'h22, 3'd1, 1, 0);
        @(negedge clk);
        checking = 0;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y, 0);
        check("midrst_err", err, 0);
        check("midrst_count", out_count, 0);
        check("midrst_in_ready", in_ready, 1);
        q.delete();
        m_seq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        checking = 1;
        send(8'h0F, 8'hFF, 3'd1, 0, 0);
        drain();
        check("postrst_y", got_y, 8'hFF);
        check("postrst_count", got_cnt, 1);

        ready_mode = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) @(negedge clk);
            send(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end
        if (m_seq) send(8'h00, 8'h00, 3'd1, 1, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_logic_pipe.md
MUX_LOGIC_PIPE -- requirements
Module: mux_logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 4: width of the beat counter.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: the input beat is valid.
REQ-006 SHALL have port in_ready  output  1: the block accepts a beat this cycle.
REQ-007 SHALL have port a  input  WIDTH: operand A, used as the per-bit mux select.
REQ-008 SHALL have port b  input  WIDTH: operand B.
REQ-009 SHALL have port op  input  3: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 PASS_A; 7 is illegal.
REQ-010 SHALL have port acc_mode  input  1: the beat belongs to an accumulation sequence.
REQ-011 SHALL have port last  input  1: final beat of an accumulation sequence.
REQ-012 SHALL have port out_valid  output  1: the result is valid.
REQ-013 SHALL have port out_ready  input  1: the downstream accepts the result.
REQ-014 SHALL have port y  output  WIDTH: the result.
REQ-015 SHALL have port err  output  1: an illegal op was seen in the delivered result.
REQ-016 SHALL have port out_count  output  CNT_W: number of beats in the delivered result.

Function
REQ-017 SHALL compute every result bit i through a 2:1 mux with select a[i]: AND=mux(0,b), OR=mux(b,1), NAND=mux(1,~b), NOR=mux(~b,0), XOR=mux(b,~b), XNOR=mux(~b,b), PASS_A=mux(0,1).
REQ-018 SHALL produce an all-zero result and flag err when op=7.
REQ-019 SHALL accept a beat exactly when in_valid && in_ready, with in_ready = !out_valid || out_ready in every state.
REQ-020 SHALL register results into y/err/out_count with 1-cycle latency: out_valid rises in the cycle after the delivering beat is accepted.
REQ-021 SHALL hold y, err, out_count and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL use an FSM with states IDLE and ACC.
REQ-023 SHALL, in IDLE with acc_mode=0 or last=1: deliver op(a,b) with err=(op==7) and out_count=1, and stay in IDLE.
REQ-024 SHALL, in IDLE with acc_mode=1 and last=0: set acc <= op(a,b), err_acc <= (op==7) and cnt <= 1, produce no output, and go to ACC.
REQ-025 SHALL, in ACC, for each accepted beat: compute op(acc,b) with acc taking the select role and a ignored; acc_mode is ignored.
REQ-026 SHALL, in ACC on a beat with last=0: update acc, OR err_acc with (op==7), and increment cnt, saturating at 2^CNT_W-1.
REQ-027 SHALL, in ACC on a beat with last=1: deliver op(acc,b) with err=err_acc|(op==7) and out_count=cnt+1 (saturating), then return to IDLE.
REQ-028 SHALL keep an undelivered result in the output register while a new accumulation proceeds, i.e. stalls only through in_ready.
REQ-029 SHALL let the output register load a new result in the same cycle the old one is taken (out_valid && out_ready with an accepted delivering beat), giving full throughput.
REQ-030 SHALL treat WIDTH=1 identically, bit 0 only.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear out_valid, y, err, out_count, acc, err_acc and cnt to 0, set the state to IDLE, and force in_ready to 1 after reset.
REQ-032 SHALL discard any partial accumulation on reset mid-sequence; the first beat after reset is treated as an IDLE beat.

Structure
REQ-033 SHALL place the op encodings (OP_AND..OP_PASS_A, OP_ILLEGAL) and the FSM state type in the shared package mux_logic_pkg.
REQ-034 SHALL instantiate a single-bit 2:1 mux sub-module, mux2_cell, WIDTH times through a generate loop; the gate decode selects only the mux data inputs.

Verification (WIDTH=8)
REQ-035 Single beat: a=F0, b=CC, op XOR/AND/NOR -> y=3C/C0/03, err=0, out_count=1, one cycle after acceptance.
REQ-036 Accumulation: (a=FF, b=0F, AND, acc_mode=1), (b=3C, OR), (b=FF, XOR, last=1) -> exactly one output, y=C0, out_count=3, err=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles with a result pending -> in_ready=0, y held stable, no beat lost; the next result follows back-to-back once out_ready=1.
REQ-038 Illegal op: a=AA, b=55, op=7 -> y=00, err=1; op=7 on the middle beat of a 3-beat accumulation -> final err=1.
REQ-039 Reset mid-accumulation after 2 beats -> outputs 0 immediately; the next single beat a=0F, b=FF, OR -> y=FF, out_count=1.
REQ-040 Saturation: with CNT_W=2, a 6-beat accumulation -> out_count=3.
